// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative shift-add multiplier / restoring divider owning the HI/LO pair.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic [WIDTH-1:0] dataIn1,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_hi, r_lo, r_a, r_b, r_m;
  logic [CW-1:0] r_cnt;
  logic r_done, r_dbz, r_div, r_sa, r_sb, r_zero;
  logic w_md, w_s0, w_s1, w_last, w_ge;
  logic [WIDTH-1:0] w_abs0, w_abs1, w_sub, w_quo, w_rem;
  logic [WIDTH:0] w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod, w_res;
  assign w_md   = funct[5:2] == 4'b0110;
  assign w_s0   = ~funct[0] & dataIn0[WIDTH-1];
  assign w_s1   = ~funct[0] & dataIn1[WIDTH-1];
  assign w_abs0 = w_s0 ? -dataIn0 : dataIn0;
  assign w_abs1 = w_s1 ? -dataIn1 : dataIn1;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  // Multiply: add multiplicand into the upper half when the low multiplier bit is set, then shift right.
  assign w_sum   = {1'b0, r_a} + (r_b[0] ? {1'b0, r_m} : '0);
  // Divide: shift next dividend bit into the partial remainder and try subtracting the divisor.
  assign w_shift = {r_a, r_b[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_m};
  assign w_sub   = w_shift[WIDTH-1:0] - r_m;
  assign w_prod  = (r_sa ^ r_sb) ? -{r_a, r_b} : {r_a, r_b};
  assign w_quo   = (r_sa ^ r_sb) ? -r_b : r_b;
  assign w_rem   = r_sa ? -r_a : r_a;
  assign w_res   = r_div ? {w_rem, w_quo} : w_prod;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? ((start && w_md) ? CALC : IDLE) :
             r_state == CALC ? (w_last ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_div  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && start) begin
        if (w_md) begin
          r_div  <= funct[1];
          r_sa   <= w_s0;
          r_sb   <= w_s1;
          r_zero <= dataIn1 == '0;
          r_a    <= '0;
          r_b    <= funct[1] ? w_abs0 : w_abs1;
          r_m    <= funct[1] ? w_abs1 : w_abs0;
          r_cnt  <= '0;
        end else if (funct == 6'h11) r_hi <= dataIn0;
        else if (funct == 6'h13) r_lo <= dataIn0;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_div) begin
          r_a <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_b <= {r_b[WIDTH-2:0], w_ge};
        end else {r_a, r_b} <= {w_sum, r_b[WIDTH-1:1]};
      end else if (r_state == FIX) begin
        r_done <= 1'b1;
        r_dbz  <= r_div && r_zero;
        if (!(r_div && r_zero)) {r_hi, r_lo} <= w_res;
      end
    end
  end
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign divByZero = r_dbz;
  assign hi        = r_hi;
  assign lo        = r_lo;
endmodule
